// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Multi-read-port integer register file for the RV32IM pipeline, with
//   same-cycle write-to-read bypass, optional hardwired-zero register 0 and a
//   per-register pending-write scoreboard used by decode for RAW hazards.
//
// Ports
//   CLK             clock, all state updates on the rising edge
//   RESET           asynchronous active-high reset
//   IN              write data
//   INADDRESS       write index
//   WRITE           write enable (also releases the index's reservation)
//   OUTADDRESS      read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   OUT             read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   BUSY            port k's register has an outstanding reservation
//   RESERVE         mark RESERVEADDRESS pending
//   RESERVEADDRESS  index to reserve
//   PENDING_COUNT   number of registers currently reserved (registered)
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [DATA_WIDTH-1:0]          IN,
    input  logic [ADDR_WIDTH-1:0]          INADDRESS,
    input  logic                           WRITE,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
    output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
    output logic [NUM_READ-1:0]            BUSY,
    input  logic                           RESERVE,
    input  logic [ADDR_WIDTH-1:0]          RESERVEADDRESS,
    output logic [ADDR_WIDTH:0]            PENDING_COUNT
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_next;
    logic                  write_ok;
    logic                  reserve_ok;

    // Register 0 swallows writes and reservations when hardwired to zero.
    assign write_ok   = WRITE   && !(HAS_ZERO && (INADDRESS == '0));
    assign reserve_ok = RESERVE && !(HAS_ZERO && (RESERVEADDRESS == '0));

    // Release first, then set: a new producer issued on the same edge as the
    // old one retires keeps the register pending.
    always_comb begin
        pend_next = pend;
        if (WRITE) begin
            pend_next[INADDRESS] = 1'b0;
        end
        if (reserve_ok) begin
            pend_next[RESERVEADDRESS] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs <= '{default: '0};
        end else if (write_ok) begin
            regs[INADDRESS] <= IN;
        end
    end

    // Count is taken from pend_next so it lands on the same edge as pend.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend          <= '0;
            PENDING_COUNT <= '0;
        end else begin
            pend          <= pend_next;
            PENDING_COUNT <= (ADDR_WIDTH+1)'($countones(pend_next));
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;
        logic                  zero;

        assign addr = OUTADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit  = WRITE && (INADDRESS == addr);
        assign zero = HAS_ZERO && (addr == '0);

        // Outputs are forced low during reset so a held WRITE cannot leak
        // through the bypass path.
        assign OUT[k*DATA_WIDTH +: DATA_WIDTH] =
            (RESET || zero)     ? '0 :
            (hit && write_ok)   ? IN :
                                  regs[addr];

        // A value arriving this cycle via bypass is not reported busy.
        assign BUSY[k] = !(RESET || zero || hit) && pend[addr];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default configuration, register 0 hardwired to zero
    logic [31:0] a_in;
    logic [4:0]  a_inaddr;
    logic        a_wr;
    logic [9:0]  a_outaddr;
    logic [63:0] a_out;
    logic [1:0]  a_busy;
    logic        a_rsv;
    logic [4:0]  a_rsvaddr;
    logic [5:0]  a_cnt;

    // Instance B: wide data, 16 entries, 4 read ports, register 0 ordinary
    logic [63:0]  b_in;
    logic [3:0]   b_inaddr;
    logic         b_wr;
    logic [15:0]  b_outaddr;
    logic [255:0] b_out;
    logic [3:0]   b_busy;
    logic         b_rsv;
    logic [3:0]   b_rsvaddr;
    logic [4:0]   b_cnt;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) u_a (
        .CLK(clk), .RESET(rst), .IN(a_in), .INADDRESS(a_inaddr), .WRITE(a_wr),
        .OUTADDRESS(a_outaddr), .OUT(a_out), .BUSY(a_busy), .RESERVE(a_rsv),
        .RESERVEADDRESS(a_rsvaddr), .PENDING_COUNT(a_cnt)
    );

    reg_file_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(4), .ZERO_REG(0)) u_b (
        .CLK(clk), .RESET(rst), .IN(b_in), .INADDRESS(b_inaddr), .WRITE(b_wr),
        .OUTADDRESS(b_outaddr), .OUT(b_out), .BUSY(b_busy), .RESERVE(b_rsv),
        .RESERVEADDRESS(b_rsvaddr), .PENDING_COUNT(b_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model A: architectural contents and set of reserved indices
    bit [31:0] ma_regs [32];
    bit        ma_pend [32];

    function automatic logic [31:0] a_exp_out(input logic [4:0] ad);
        if (rst || ad == 0) return 32'h0;
        if (a_wr && a_inaddr == ad) return a_in;
        return ma_regs[ad];
    endfunction

    function automatic logic a_exp_busy(input logic [4:0] ad);
        if (rst || ad == 0) return 1'b0;
        if (a_wr && a_inaddr == ad) return 1'b0;
        return ma_pend[ad];
    endfunction

    function automatic int a_pend_total();
        int n = 0;
        foreach (ma_pend[i]) n += int'(ma_pend[i]);
        return n;
    endfunction

    task automatic a_set(input logic wr, input int wa, input logic [31:0] d,
                         input logic rs, input int ra, input int o0, input int o1);
        a_wr      = wr;
        a_inaddr  = 5'(wa);
        a_in      = d;
        a_rsv     = rs;
        a_rsvaddr = 5'(ra);
        a_outaddr = {5'(o1), 5'(o0)};
    endtask

    task automatic a_cycle();
        logic [4:0] ad;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ad = a_outaddr[k*5 +: 5];
            chk($sformatf("a_out%0d@%0d", k, ad), 64'(a_out[k*32 +: 32]), 64'(a_exp_out(ad)));
            chk($sformatf("a_busy%0d@%0d", k, ad), 64'(a_busy[k]), 64'(a_exp_busy(ad)));
        end
        chk("a_cnt", 64'(a_cnt), rst ? 64'd0 : 64'(a_pend_total()));
        if (rst) begin
            foreach (ma_regs[i]) begin
                ma_regs[i] = '0;
                ma_pend[i] = 1'b0;
            end
        end else begin
            if (a_wr && a_inaddr != 0) ma_regs[a_inaddr] = a_in;
            if (a_wr) ma_pend[a_inaddr] = 1'b0;
            if (a_rsv && a_rsvaddr != 0) ma_pend[a_rsvaddr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model B
    bit [63:0] mb_regs [16];
    bit        mb_pend [16];

    function automatic logic [63:0] b_exp_out(input logic [3:0] ad);
        if (rst) return 64'h0;
        if (b_wr && b_inaddr == ad) return b_in;
        return mb_regs[ad];
    endfunction

    function automatic logic b_exp_busy(input logic [3:0] ad);
        if (rst) return 1'b0;
        if (b_wr && b_inaddr == ad) return 1'b0;
        return mb_pend[ad];
    endfunction

    function automatic int b_pend_total();
        int n = 0;
        foreach (mb_pend[i]) n += int'(mb_pend[i]);
        return n;
    endfunction

    task automatic b_set(input logic wr, input int wa, input logic [63:0] d,
                         input logic rs, input int ra,
                         input int o0, input int o1, input int o2, input int o3);
        b_wr      = wr;
        b_inaddr  = 4'(wa);
        b_in      = d;
        b_rsv     = rs;
        b_rsvaddr = 4'(ra);
        b_outaddr = {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
    endtask

    task automatic b_cycle();
        logic [3:0] ad;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ad = b_outaddr[k*4 +: 4];
            chk($sformatf("b_out%0d@%0d", k, ad), b_out[k*64 +: 64], b_exp_out(ad));
            chk($sformatf("b_busy%0d@%0d", k, ad), 64'(b_busy[k]), 64'(b_exp_busy(ad)));
        end
        chk("b_cnt", 64'(b_cnt), rst ? 64'd0 : 64'(b_pend_total()));
        if (rst) begin
            foreach (mb_regs[i]) begin
                mb_regs[i] = '0;
                mb_pend[i] = 1'b0;
            end
        end else begin
            if (b_wr) begin
                mb_regs[b_inaddr] = b_in;
                mb_pend[b_inaddr] = 1'b0;
            end
            if (b_rsv) mb_pend[b_rsvaddr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Biased toward a few low indices so bypass and hazard collisions occur often.
    function automatic int rnd_idx(input int max);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, max));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        b_set(0, 0, 64'h0, 0, 0, 0, 1, 2, 3);
        // Write and reserve held during reset must be ignored
        a_set(1, 5, 32'hAAAA_5555, 1, 5, 5, 6);
        a_cycle();
        a_cycle();
        rst = 1'b0;

        // Basic write, then read back on the next cycle
        a_set(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 6);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 5, 6);
        a_cycle();

        // Bypass on both ports
        a_set(1, 7, 32'h11, 0, 0, 7, 7);
        a_cycle();
        a_set(1, 7, 32'h22, 0, 0, 7, 7);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 7, 5);
        a_cycle();

        // Hardwired zero register
        a_set(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 0, 7);
        a_cycle();

        // Scoreboard: two reservations, collide write+reserve, then release
        a_set(0, 0, 32'h0, 1, 3, 3, 4);
        a_cycle();
        a_set(0, 0, 32'h0, 1, 4, 3, 4);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 3, 4);
        a_cycle();
        a_set(1, 3, 32'h33, 1, 3, 3, 4);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 3, 4);
        a_cycle();
        a_set(1, 4, 32'h44, 0, 0, 3, 4);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 3, 4);
        a_cycle();

        // Async reset between edges with three reservations outstanding
        a_set(1, 1, 32'h0101, 1, 5, 1, 3);
        a_cycle();
        a_set(1, 2, 32'h0202, 1, 6, 5, 6);
        a_cycle();
        a_set(1, 9, 32'h0999, 0, 0, 3, 9);
        rst = 1'b1;
        #2;
        chk("arst_out", a_out, 64'h0);
        chk("arst_busy", 64'(a_busy), 64'h0);
        chk("arst_cnt", 64'(a_cnt), 64'h0);
        a_cycle();
        rst = 1'b0;
        a_set(0, 0, 32'h0, 0, 0, 9, 3);
        a_cycle();
        a_set(0, 0, 32'h0, 0, 0, 1, 5);
        a_cycle();

        // Randomized traffic on A
        for (int i = 0; i < 300; i++) begin
            a_set(logic'($urandom_range(0, 1)), rnd_idx(31), $urandom,
                  logic'($urandom_range(0, 2) == 0), rnd_idx(31), rnd_idx(31), rnd_idx(31));
            a_cycle();
        end

        // Instance B
        rst = 1'b1;
        b_set(1, 2, 64'h5A5A, 1, 2, 0, 1, 2, 3);
        b_cycle();
        rst = 1'b0;
        b_set(1, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, 0);
        b_cycle();
        b_set(0, 0, 64'h0, 0, 0, 0, 0, 0, 0);
        b_cycle();
        for (int i = 0; i < 16; i++) begin
            b_set(0, 0, 64'h0, 1, i, i, 0, 15, 8);
            b_cycle();
        end
        b_set(0, 0, 64'h0, 0, 0, 0, 5, 10, 15);
        b_cycle();
        for (int i = 0; i < 200; i++) begin
            b_set(logic'($urandom_range(0, 1)), rnd_idx(15), {$urandom, $urandom},
                  logic'($urandom_range(0, 2) == 0), rnd_idx(15),
                  rnd_idx(15), rnd_idx(15), rnd_idx(15), rnd_idx(15));
            b_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
